// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared constants and types for the MIPS fetch path:
//                next-PC select codes, reset PC, canonical NOP, fetch FSM
//                state type and the branch-offset helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [1:0]  NPC_SEQ  = 2'b00;
    localparam logic [1:0]  NPC_BEQ  = 2'b01;
    localparam logic [1:0]  NPC_J    = 2'b10;
    localparam logic [1:0]  NPC_JR   = 2'b11;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_t;

    // Word offset of a beq immediate as a byte displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface   : if_stage_if
//  Description : Bundle between the fetch stage and its neighbours (hazard
//                unit, ID stage, instruction memory). The slave modport is
//                the fetch stage; master is everything around it.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_stage_if #(
    parameter int IM_AW = 10
);
    logic             stall;
    logic [1:0]       npc_sel;
    logic             br_taken;
    logic [15:0]      id_imm16;
    logic [25:0]      id_target26;
    logic [31:0]      id_rs_val;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_instr;
    logic [31:0]      pc;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc4;
    logic             id_valid;
    logic             fetch_fault;

    modport slave (
        input  stall, npc_sel, br_taken, id_imm16, id_target26, id_rs_val,
        input  im_instr,
        output im_addr, pc, id_instr, id_pc4, id_valid, fetch_fault
    );

    modport master (
        output stall, npc_sel, br_taken, id_imm16, id_target26, id_rs_val,
        output im_instr,
        input  im_addr, pc, id_instr, id_pc4, id_valid, fetch_fault
    );
endinterface
`default_nettype wire

// File: rtl/if_stage_npc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : npc_calc
//  Description : Combinational next-PC selection. Redirects come from the
//                instruction currently in ID and are honoured only when that
//                slot holds a real instruction; otherwise fetch is sequential.
//  Revision    : 1.0  initial release
// ============================================================================
module npc_calc
    import mips_pkg::*;
(
    input  wire logic [31:0] i_pc4,
    input  wire logic [31:0] i_id_pc4,
    input  wire logic        i_id_valid,
    input  wire logic [1:0]  i_npc_sel,
    input  wire logic        i_br_taken,
    input  wire logic [15:0] i_id_imm16,
    input  wire logic [25:0] i_id_target26,
    input  wire logic [31:0] i_id_rs_val,
    output logic      [31:0] o_npc
);

    // Select the next fetch address; all adds wrap modulo 2**32
    always_comb begin
        o_npc = i_pc4;
        if (i_id_valid) begin
            case (i_npc_sel)
                NPC_BEQ: if (i_br_taken) o_npc = i_id_pc4 + branch_offset(i_id_imm16);
                NPC_J:   o_npc = {i_id_pc4[31:28], i_id_target26, 2'b00};
                NPC_JR:  o_npc = i_id_rs_val;
                default: o_npc = i_pc4;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : MIPS instruction-fetch stage. Owns the PC, indexes the
//                word-addressed IM, latches IF/ID and tracks a sticky fetch
//                fault when the PC leaves the IM window or is misaligned.
//                Branch delay slot is architectural: nothing is squashed.
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
    parameter int          IM_AW    = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    if_stage_if.slave   bus
);

    // IM window as 33-bit bounds so the upper limit cannot wrap
    localparam logic [32:0] c_WIN_LO = {1'b0, PC_RESET};
    localparam logic [32:0] c_WIN_HI = c_WIN_LO + (33'd4 << IM_AW);

    logic [31:0]  r_pc;
    logic [31:0]  r_id_instr;
    logic [31:0]  r_id_pc4;
    logic         r_id_valid;
    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         w_load_valid;
    logic         w_fetch_ok;
    logic [31:0]  w_pc4;
    logic [31:0]  w_npc;

    assign w_pc4      = r_pc + 32'd4;
    assign w_fetch_ok = (r_pc[1:0] == 2'b00) &&
                        ({1'b0, r_pc} >= c_WIN_LO) &&
                        ({1'b0, r_pc} <  c_WIN_HI);

    npc_calc u_npc_calc (
        .i_pc4         (w_pc4),
        .i_id_pc4      (r_id_pc4),
        .i_id_valid    (r_id_valid),
        .i_npc_sel     (bus.npc_sel),
        .i_br_taken    (bus.br_taken),
        .i_id_imm16    (bus.id_imm16),
        .i_id_target26 (bus.id_target26),
        .i_id_rs_val   (bus.id_rs_val),
        .o_npc         (w_npc)
    );

    // Fault FSM state register; only reset leaves FAULT
    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH_RUN;
        else       r_state <= w_state_nxt;
    end

    // Fault FSM next state and validity of the instruction being loaded
    always_comb begin
        w_state_nxt  = r_state;
        w_load_valid = 1'b0;
        case (r_state)
            FETCH_RUN: begin
                w_load_valid = w_fetch_ok;
                if (!bus.stall && !w_fetch_ok) w_state_nxt = FETCH_FAULT;
            end
            FETCH_FAULT: begin
                w_load_valid = 1'b0;
            end
            default: begin
                w_state_nxt = FETCH_RUN;
            end
        endcase
    end

    // PC register and IF/ID latch; a stall freezes both, reset overrides all
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= PC_RESET;
            r_id_instr <= NOP;
            r_id_pc4   <= 32'd0;
            r_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_pc       <= w_npc;
            r_id_instr <= w_fetch_ok ? bus.im_instr : NOP;
            r_id_pc4   <= w_pc4;
            r_id_valid <= w_load_valid;
        end
    end

    assign bus.im_addr     = r_pc[IM_AW+1:2];
    assign bus.pc          = r_pc;
    assign bus.id_instr    = r_id_instr;
    assign bus.id_pc4      = r_id_pc4;
    assign bus.id_valid    = r_id_valid;
    assign bus.fetch_fault = (r_state == FETCH_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage: directed vector table for
//                the reset/branch/jump/stall/fault sequences, then randomized
//                traffic checked against a behavioural fetch model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;
    import mips_pkg::*;

    localparam int IM_AW = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    if_stage_if #(.IM_AW(IM_AW)) bus ();

    if_stage #(.PC_RESET(32'h0000_3000), .IM_AW(IM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Instruction memory contents: a distinct word per index
    function automatic logic [31:0] imword(input logic [9:0] idx);
        return 32'hC300_0000 ^ {idx, 6'h15, idx, 6'h2A};
    endfunction

    assign bus.im_instr = imword(bus.im_addr);

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault;

    task automatic model_step(input logic r, input logic s, input logic [1:0] sel,
                              input logic t, input logic [15:0] imm,
                              input logic [25:0] tgt, input logic [31:0] rs);
        logic        ok;
        logic [31:0] nxt;
        if (r) begin
            m_pc = 32'h3000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
        end else if (!s) begin
            ok  = (m_pc % 4 == 0) && (m_pc >= 32'h3000) && (m_pc < 32'h3000 + 4 * 1024);
            nxt = m_pc + 4;
            if (m_valid) begin
                if (sel == 2'd1 && t) nxt = m_pc4 + 32'(int'($signed(imm)) * 4);
                else if (sel == 2'd2) nxt = (m_pc4 & 32'hF000_0000) + {4'h0, tgt, 2'b00};
                else if (sel == 2'd3) nxt = rs;
            end
            m_instr = ok ? imword(m_pc[11:2]) : 32'h0;
            m_pc4   = m_pc + 4;
            m_valid = ok && !m_fault;
            m_fault = m_fault || !ok;
            m_pc    = nxt;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, sample after the edge
    task automatic cycle(input logic r, input logic s, input logic [1:0] sel,
                         input logic t, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] rs);
        reset           = r;
        bus.stall       = s;
        bus.npc_sel     = sel;
        bus.br_taken    = t;
        bus.id_imm16    = imm;
        bus.id_target26 = tgt;
        bus.id_rs_val   = rs;
        @(posedge clk);
        model_step(r, s, sel, t, imm, tgt, rs);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic        taken;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] rs;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t tv[$];

    initial begin
        logic [31:0] e_instr;
        reset = 1'b1; bus.stall = 0; bus.npc_sel = 0; bus.br_taken = 0;
        bus.id_imm16 = 0; bus.id_target26 = 0; bus.id_rs_val = 0;

        //           rst st sel tk imm       tgt        rs            pc            pc4        v  f
        // sequential fetch from reset
        tv.push_back('{1, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3000, 32'h0,    0, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3004, 32'h3004, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3008, 32'h3008, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h300C, 32'h300C, 1, 0});
        // beq at 0x3004, offset -1: delay slot 0x3008 latched, then refetch 0x3004
        tv.push_back('{1, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3000, 32'h0,    0, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3004, 32'h3004, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3008, 32'h3008, 1, 0});
        tv.push_back('{0, 0, 1, 1, 16'hFFFF, 26'h0,     32'h0,      32'h3004, 32'h300C, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3008, 32'h3008, 1, 0});
        // j with id_pc4=0x3008
        tv.push_back('{0, 0, 2, 0, 16'h0,    26'h0C10,  32'h0,      32'h3040, 32'h300C, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3044, 32'h3044, 1, 0});
        // jr held by two stall cycles
        tv.push_back('{0, 1, 3, 0, 16'h0,    26'h0,     32'h3010,   32'h3044, 32'h3044, 1, 0});
        tv.push_back('{0, 1, 3, 0, 16'h0,    26'h0,     32'h3010,   32'h3044, 32'h3044, 1, 0});
        tv.push_back('{0, 0, 3, 0, 16'h0,    26'h0,     32'h3010,   32'h3010, 32'h3048, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3014, 32'h3014, 1, 0});
        // jr out of window: sticky fault, redirects ignored, reset clears
        tv.push_back('{0, 0, 3, 0, 16'h0,    26'h0,     32'h5000,   32'h5000, 32'h3018, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h5004, 32'h5004, 0, 1});
        tv.push_back('{0, 0, 1, 1, 16'h0010, 26'h0,     32'h0,      32'h5008, 32'h5008, 0, 1});
        tv.push_back('{1, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3000, 32'h0,    0, 0});
        // reset together with taken beq, then reset together with stall
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3004, 32'h3004, 1, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3008, 32'h3008, 1, 0});
        tv.push_back('{1, 0, 1, 1, 16'h0010, 26'h0,     32'h0,      32'h3000, 32'h0,    0, 0});
        tv.push_back('{0, 0, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3004, 32'h3004, 1, 0});
        tv.push_back('{1, 1, 0, 0, 16'h0,    26'h0,     32'h0,      32'h3000, 32'h0,    0, 0});

        for (int i = 0; i < tv.size(); i++) begin
            cycle(tv[i].rst, tv[i].stall, tv[i].sel, tv[i].taken,
                  tv[i].imm, tv[i].tgt, tv[i].rs);
            e_instr = tv[i].e_valid ? imword(10'((tv[i].e_pc4 - 32'd4) >> 2)) : 32'h0;
            chk($sformatf("vec%0d pc", i),          bus.pc,                tv[i].e_pc);
            chk($sformatf("vec%0d id_pc4", i),      bus.id_pc4,            tv[i].e_pc4);
            chk($sformatf("vec%0d id_valid", i),    32'(bus.id_valid),     32'(tv[i].e_valid));
            chk($sformatf("vec%0d fetch_fault", i), 32'(bus.fetch_fault),  32'(tv[i].e_fault));
            chk($sformatf("vec%0d id_instr", i),    bus.id_instr,          e_instr);
            chk($sformatf("vec%0d im_addr", i),     32'(bus.im_addr),      32'(tv[i].e_pc[11:2]));
        end

        // Randomized traffic against the behavioural model
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 800; n++) begin
            logic        r, s, t;
            logic [1:0]  sel;
            logic [15:0] imm;
            logic [25:0] tgt;
            logic [31:0] rs;
            int          pick;
            r    = ($urandom_range(0, 49) == 0);
            s    = ($urandom_range(0, 3) == 0);
            sel  = 2'($urandom_range(0, 3));
            t    = 1'($urandom_range(0, 1));
            imm  = 16'(int'($urandom_range(0, 40)) - 20);
            tgt  = 26'(32'h0C00 + $urandom_range(0, 1023));
            pick = int'($urandom_range(0, 19));
            if (pick == 0)      rs = 32'h5000;
            else if (pick == 1) rs = 32'h3002;
            else                rs = 32'h3000 + 4 * $urandom_range(0, 1023);
            cycle(r, s, sel, t, imm, tgt, rs);
            chk($sformatf("rnd%0d pc", n),          bus.pc,               m_pc);
            chk($sformatf("rnd%0d id_instr", n),    bus.id_instr,         m_instr);
            chk($sformatf("rnd%0d id_pc4", n),      bus.id_pc4,           m_pc4);
            chk($sformatf("rnd%0d id_valid", n),    32'(bus.id_valid),    32'(m_valid));
            chk($sformatf("rnd%0d fetch_fault", n), 32'(bus.fetch_fault), 32'(m_fault));
            chk($sformatf("rnd%0d im_addr", n),     32'(bus.im_addr),     32'(m_pc[11:2]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
